pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 Parameter W, default 32, operand/result width in bits (W >= 1).
REQ-002 Parameter S, default 4, number of pipeline stages; chunk width CW = W/S.
REQ-003 clk  input  1  rising-edge clock, sole clock domain.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 a  input  W  operand A, unsigned or two's complement.
REQ-006 b  input  W  operand B.
REQ-007 ci  input  1  carry-in (add) / borrow-in (sub).
REQ-008 sub  input  1  0: add, 1: subtract; sampled with the operands.
REQ-009 i_valid  input  1  a, b, ci and sub are valid this cycle.
REQ-010 i_ready  output  1  block accepts the operand set this cycle.
REQ-011 s  output  W  result.
REQ-012 co  output  1  carry-out (add) / not-borrow (sub).
REQ-013 ov  output  1  two's-complement overflow of s.
REQ-014 o_valid  output  1  s, co and ov are valid.
REQ-015 o_ready  input  1  consumer accepts the result this cycle.

Function
REQ-016 The operand set shall be accepted on a rising edge when i_valid && i_ready.
REQ-017 The result shall be consumed on a rising edge when o_valid && o_ready.
REQ-018 i_ready shall equal o_ready || !o_valid; this signal is the global pipeline advance enable.
REQ-019 Add mode shall compute {co,s} = a + b + ci; sub mode shall compute {co,s} = a + ~b + ~ci, i.e. a - b - ci, with co = 1 meaning no borrow.
REQ-020 ov shall equal (A[W-1] == B'[W-1]) && (s[W-1] != A[W-1]), where B' is b or ~b per sub.
REQ-021 Stage k (0..S-1) shall add chunk k (bits k*CW+CW-1 : k*CW) using the registered carry of stage k-1; stage 0 shall use the effective carry-in.
REQ-022 Upper operand chunks shall be skew-delayed and lower sum chunks deskewed, so that s, co and ov of one operand set emerge together.
REQ-023 Latency shall be exactly S cycles from acceptance to o_valid when unstalled; throughput shall be one result per cycle.
REQ-024 While advance is low, all stage registers shall hold, and no operand set shall be lost, duplicated or reordered.
REQ-025 Bubbles (i_valid = 0) shall propagate as invalid stages and shall not stall the pipeline.
REQ-026 With S = 1, the block shall be a single registered adder with latency 1.
REQ-027 W not divisible by S, or S < 1, shall cause an elaboration error.
REQ-028 s, co and ov shall be stable while o_valid && !o_ready.

Reset
REQ-029 Asserting reset_n low shall immediately clear all stage valid flags, o_valid, s, co and ov to 0, including mid-operation; in-flight sets shall be discarded.
REQ-030 While reset is asserted, i_ready shall be 1, since it is derived from o_valid = 0.
REQ-031 After reset release, the first accepted set shall appear after exactly S cycles.

Structure
REQ-032 No shared package is required; W, S and CW shall be module parameters/localparams.
REQ-033 One sub-module, adder_stage, shall be used: a CW-bit adder with a registered sum chunk and carry, enable and valid, instantiated S times via a generate loop.

Verification
REQ-034 W=8, S=2: a=0xFF, b=0x01, ci=0, sub=0 -> s=0x00, co=1, ov=0 exactly 2 cycles after acceptance.
REQ-035 W=8, S=2: a=0x7F, b=0x01, add -> s=0x80, ov=1, co=0; a=0x05, b=0x07, sub, ci=0 -> s=0xFE, co=0, ov=0.
REQ-036 Backpressure: stream 0x10+0x01, 0x20+0x02, 0x30+0x03 with o_ready=0 for 5 cycles -> i_ready falls, then results 0x11, 0x22, 0x33 in order with none lost.
REQ-037 Reset mid-operation: 2 sets in flight, reset_n pulsed low -> o_valid=0 immediately and no stale result after release; the next set returns with latency S.
REQ-038 Exhaustive check, W=4, S=2: all 256 (a,b) pairs x ci x sub with random i_valid/o_ready -> every result matches the reference model, one result per accepted set.
REQ-039 S=1, W=8: 0x80+0x80 -> s=0x00, co=1, ov=1 after 1 cycle.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// Shared helpers for the pipelined adder: geometry check and overflow rule.
package pipelined_adder_pkg;

    // True when the operand width splits evenly into the requested stages.
    function automatic bit geometry_ok(input int w, input int s);
        return (s >= 1) && (w >= 1) && ((w % s) == 0);
    endfunction

    // Two's-complement overflow from the operand sign bits and the result sign bit.
    function automatic logic ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/pipelined_adder_adder_stage.sv
// One CW-bit slice of the pipelined adder: registered sum chunk, carry and valid.
module adder_stage #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en_i,
    input  logic          vld_i,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic          vld_o,
    output logic [CW-1:0] sum_o,
    output logic          c_o
);

    logic [CW-1:0] sum_d, sum_q;
    logic          c_d, c_q;
    logic          vld_q;

    // Chunk add including the incoming carry.
    always_comb begin
        {c_d, sum_d} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
    end

    // Stage register: holds while the pipeline is not advancing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            vld_q <= 1'b0;
        end else if (en_i) begin
            sum_q <= sum_d;
            c_q   <= c_d;
            vld_q <= vld_i;
        end
    end

    assign sum_o = sum_q;
    assign c_o   = c_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/pipelined_adder.sv
// S-stage carry-pipelined adder/subtractor with valid/ready handshake.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int W = 32,
    parameter int S = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    input  logic         sub,
    input  logic         i_valid,
    output logic         i_ready,
    output logic [W-1:0] s,
    output logic         co,
    output logic         ov,
    output logic         o_valid,
    input  logic         o_ready
);

    localparam int CW = (S >= 1) ? (W / S) : 1;

    if (!geometry_ok(W, S)) begin : g_bad_geometry
        $error("pipelined_adder: W must be a positive multiple of S, with S >= 1");
    end

    logic                   adv;
    logic [W-1:0]           bp;
    logic                   cin_eff;
    logic [S-1:0]           vld;
    logic [S-1:0]           cy;
    logic [S-1:0][CW-1:0]   sum_ch;
    logic [S-1:0][CW-1:0]   a_in;
    logic [S-1:0][CW-1:0]   b_in;
    logic [W-1:0]           s_w;
    logic                   amsb_d, amsb_q;
    logic                   bmsb_d, bmsb_q;

    assign adv     = o_ready || !o_valid;
    assign i_ready = adv;

    // Subtraction is a + ~b + ~ci, so only B and the carry-in are conditioned.
    always_comb begin
        bp      = sub ? ~b : b;
        cin_eff = sub ? ~ci : ci;
    end

    // Chunk 0 enters stage 0 directly.
    assign a_in[0] = a[CW-1:0];
    assign b_in[0] = bp[CW-1:0];

    // Upper operand chunks wait j cycles so they meet the ripple carry at stage j.
    for (genvar j = 1; j < S; j++) begin : g_skew
        logic [CW-1:0] ad_q [j];
        logic [CW-1:0] bd_q [j];

        // Operand skew shift register for chunk j.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < j; i++) begin
                    ad_q[i] <= '0;
                    bd_q[i] <= '0;
                end
            end else if (adv) begin
                ad_q[0] <= a[j*CW +: CW];
                bd_q[0] <= bp[j*CW +: CW];
                for (int unsigned i = 1; i < j; i++) begin
                    ad_q[i] <= ad_q[i-1];
                    bd_q[i] <= bd_q[i-1];
                end
            end
        end

        assign a_in[j] = ad_q[j-1];
        assign b_in[j] = bd_q[j-1];
    end

    // Carry chain across the stages, one registered hop per stage.
    for (genvar k = 0; k < S; k++) begin : g_stage
        logic vin;
        logic cin_k;

        if (k == 0) begin : g_first
            assign vin   = i_valid;
            assign cin_k = cin_eff;
        end else begin : g_rest
            assign vin   = vld[k-1];
            assign cin_k = cy[k-1];
        end

        adder_stage #(.CW(CW)) u_stage (
            .clk     (clk),
            .reset_n (reset_n),
            .en_i    (adv),
            .vld_i   (vin),
            .a_i     (a_in[k]),
            .b_i     (b_in[k]),
            .c_i     (cin_k),
            .vld_o   (vld[k]),
            .sum_o   (sum_ch[k]),
            .c_o     (cy[k])
        );
    end

    // Lower sum chunks finish early and are delayed S-1-k cycles to line up.
    for (genvar k = 0; k < S - 1; k++) begin : g_deskew
        localparam int L = S - 1 - k;
        logic [CW-1:0] sd_q [L];

        // Sum deskew shift register for chunk k.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                for (int unsigned i = 0; i < L; i++) begin
                    sd_q[i] <= '0;
                end
            end else if (adv) begin
                sd_q[0] <= sum_ch[k];
                for (int unsigned i = 1; i < L; i++) begin
                    sd_q[i] <= sd_q[i-1];
                end
            end
        end

        assign s_w[k*CW +: CW] = sd_q[L-1];
    end

    assign s_w[(S-1)*CW +: CW] = sum_ch[S-1];

    // Operand sign bits are captured alongside the last stage for the overflow rule.
    always_comb begin
        amsb_d = a_in[S-1][CW-1];
        bmsb_d = b_in[S-1][CW-1];
    end

    // Sign-bit registers, aligned with the final stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            amsb_q <= 1'b0;
            bmsb_q <= 1'b0;
        end else if (adv) begin
            amsb_q <= amsb_d;
            bmsb_q <= bmsb_d;
        end
    end

    assign s       = s_w;
    assign co      = cy[S-1];
    assign o_valid = vld[S-1];
    assign ov      = ovf(amsb_q, bmsb_q, s_w[W-1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed self-checking bench: W=8/S=2, W=8/S=1 and an exhaustive W=4/S=2 sweep.
module tb_pipelined_adder;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    // W=8, S=2
    logic [7:0] a8, b8, s8;
    logic       ci8, sb8, iv8, ir8, co8, ov8, vo8, or8;
    // W=8, S=1
    logic [7:0] a1, b1, s1;
    logic       ci1, sb1, iv1, ir1, co1, ov1, vo1, or1;
    // W=4, S=2
    logic [3:0] a4, b4, s4;
    logic       ci4, sb4, iv4, ir4, co4, ov4, vo4, or4;

    int compared   = 0;
    int mismatched = 0;

    pipelined_adder #(.W(8), .S(2)) u8 (
        .clk(clk), .reset_n(reset_n), .a(a8), .b(b8), .ci(ci8), .sub(sb8),
        .i_valid(iv8), .i_ready(ir8), .s(s8), .co(co8), .ov(ov8),
        .o_valid(vo8), .o_ready(or8)
    );

    pipelined_adder #(.W(8), .S(1)) u1 (
        .clk(clk), .reset_n(reset_n), .a(a1), .b(b1), .ci(ci1), .sub(sb1),
        .i_valid(iv1), .i_ready(ir1), .s(s1), .co(co1), .ov(ov1),
        .o_valid(vo1), .o_ready(or1)
    );

    pipelined_adder #(.W(4), .S(2)) u4 (
        .clk(clk), .reset_n(reset_n), .a(a4), .b(b4), .ci(ci4), .sub(sb4),
        .i_valid(iv4), .i_ready(ir4), .s(s4), .co(co4), .ov(ov4),
        .o_valid(vo4), .o_ready(or4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference for the 4-bit sweep, packed as {co, ov, s}.
    function automatic logic [5:0] model4(input logic [3:0] a, input logic [3:0] b,
                                          input logic ci, input logic sub);
        logic [3:0] bb;
        logic       cc;
        logic [4:0] t;
        logic       v;
        bb = sub ? ~b : b;
        cc = sub ? ~ci : ci;
        t  = {1'b0, a} + {1'b0, bb} + {4'b0, cc};
        v  = (a[3] == bb[3]) && (t[3] != a[3]);
        return {t[4], v, t[3:0]};
    endfunction

    // One isolated operation on the W=8/S=2 instance, checking 2-cycle latency.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sub,
                       input logic [7:0] es, input logic eco, input logic eov);
        a8 = a; b8 = b; ci8 = ci; sb8 = sub; iv8 = 1'b1;
        cyc();
        iv8 = 1'b0;
        check({tag, "_early"}, {31'b0, vo8}, 32'd0);
        cyc();
        check({tag, "_valid"}, {31'b0, vo8}, 32'd1);
        check({tag, "_res"}, {22'b0, co8, ov8, s8}, {22'b0, eco, eov, es});
    endtask

    task automatic put8(input logic [7:0] a, input logic [7:0] b);
        a8 = a; b8 = b; ci8 = 1'b0; sb8 = 1'b0; iv8 = 1'b1;
    endtask

    initial begin
        int         sent;
        int         recv;
        int         cyc_n;
        logic [5:0] q[$];
        logic [5:0] exp;

        reset_n = 1'b1;
        a8 = '0; b8 = '0; ci8 = 0; sb8 = 0; iv8 = 0; or8 = 1;
        a1 = '0; b1 = '0; ci1 = 0; sb1 = 0; iv1 = 0; or1 = 1;
        a4 = '0; b4 = '0; ci4 = 0; sb4 = 0; iv4 = 0; or4 = 1;
        #2 reset_n = 1'b0;
        cyc();
        cyc();

        // Reset state
        check("rst_vo8", {31'b0, vo8}, 32'd0);
        check("rst_out8", {22'b0, co8, ov8, s8}, 32'd0);
        check("rst_ir8", {31'b0, ir8}, 32'd1);
        check("rst_vo1", {31'b0, vo1}, 32'd0);
        check("rst_vo4", {31'b0, vo4}, 32'd0);
        reset_n = 1'b1;
        cyc();

        // Directed arithmetic, W=8 S=2
        op8("ff_p_01",  8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("7f_p_01",  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8("05_m_07",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("10_m_01b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);
        op8("0f_p_01c", 8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
        op8("80_m_01",  8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        cyc();
        check("idle_vo8", {31'b0, vo8}, 32'd0);

        // Back-to-back throughput
        put8(8'h01, 8'h02);
        cyc();
        put8(8'h03, 8'h04);
        cyc();
        check("tp0", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h03});
        put8(8'h05, 8'h06);
        cyc();
        iv8 = 1'b0;
        check("tp1", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h07});
        cyc();
        check("tp2", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h0B});
        cyc();
        check("tp_end", {31'b0, vo8}, 32'd0);

        // Backpressure: o_ready low while three sets stream in
        or8 = 1'b0;
        put8(8'h10, 8'h01);
        check("bp_ir0", {31'b0, ir8}, 32'd1);
        cyc();
        put8(8'h20, 8'h02);
        check("bp_ir1", {31'b0, ir8}, 32'd1);
        cyc();
        put8(8'h30, 8'h03);
        for (int i = 0; i < 3; i++) begin
            check("bp_stall_ir", {31'b0, ir8}, 32'd0);
            check("bp_stall_out", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h11});
            cyc();
        end
        or8 = 1'b1;
        check("bp_hold_out", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h11});
        cyc();
        iv8 = 1'b0;
        check("bp_r1", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h22});
        cyc();
        check("bp_r2", {23'b0, vo8, s8}, {23'b0, 1'b1, 8'h33});
        cyc();
        check("bp_end", {31'b0, vo8}, 32'd0);

        // Reset with two sets in flight
        put8(8'h01, 8'h02);
        cyc();
        put8(8'h03, 8'h04);
        cyc();
        iv8 = 1'b0;
        check("mr_pre", {31'b0, vo8}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("mr_vo", {31'b0, vo8}, 32'd0);
        check("mr_out", {22'b0, co8, ov8, s8}, 32'd0);
        check("mr_ir", {31'b0, ir8}, 32'd1);
        cyc();
        reset_n = 1'b1;
        cyc();
        check("mr_stale0", {31'b0, vo8}, 32'd0);
        cyc();
        check("mr_stale1", {31'b0, vo8}, 32'd0);
        op8("mr_next", 8'h40, 8'h05, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0);
        cyc();

        // Single-stage instance, latency 1
        a1 = 8'h80; b1 = 8'h80; ci1 = 1'b0; sb1 = 1'b0; iv1 = 1'b1;
        cyc();
        iv1 = 1'b0;
        check("s1_valid", {31'b0, vo1}, 32'd1);
        check("s1_res", {22'b0, co1, ov1, s1}, {22'b0, 1'b1, 1'b1, 8'h00});
        cyc();
        check("s1_end", {31'b0, vo1}, 32'd0);

        // Exhaustive W=4 S=2 with random valid/ready
        sent  = 0;
        recv  = 0;
        cyc_n = 0;
        while ((sent < 1024 || q.size() > 0) && cyc_n < 20000) begin
            or4 = ($urandom_range(0, 3) != 0);
            iv4 = (sent < 1024) && ($urandom_range(0, 3) != 0);
            a4  = sent[3:0];
            b4  = sent[7:4];
            ci4 = sent[8];
            sb4 = sent[9];
            #1;
            if (vo4 && or4) begin
                if (q.size() == 0) begin
                    check("x4_extra", 32'd1, 32'd0);
                end else begin
                    exp = q.pop_front();
                    check("x4_res", {26'b0, co4, ov4, s4}, {26'b0, exp});
                    recv++;
                end
            end
            if (iv4 && ir4) begin
                q.push_back(model4(a4, b4, ci4, sb4));
                sent++;
            end
            cyc();
            cyc_n++;
        end
        iv4 = 1'b0;
        or4 = 1'b1;
        check("x4_budget", {31'b0, (cyc_n < 20000)}, 32'd1);
        check("x4_count", recv, 32'd1024);
        cyc();
        check("x4_drained", {31'b0, vo4}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
